// File: rtl/sr_sync_pkg.sv
// Shared types, default parameters and the S/R next-state rule for the bank.
package sr_sync_pkg;

    // Response of a channel when filtered S and R are both asserted.
    typedef enum logic [1:0] {
        CM_HOLD,
        CM_SET,
        CM_RESET,
        CM_FLOAT
    } conflict_mode_t;

    localparam int             DEF_CHANNELS      = 4;
    localparam int             DEF_SYNC_STAGES   = 2;
    localparam int             DEF_FILTER        = 3;
    localparam conflict_mode_t DEF_CONFLICT_MODE = CM_HOLD;

    // Next value of the state bit given filtered set/reset levels.
    // CM_FLOAT holds the state; the output drivers handle the release.
    function automatic logic next_state(input logic           fs,
                                        input logic           fr,
                                        input logic           state,
                                        input conflict_mode_t mode);
        logic nxt;
        nxt = state;
        case ({fs, fr})
            2'b10: nxt = 1'b1;
            2'b01: nxt = 1'b0;
            2'b11: begin
                case (mode)
                    CM_SET:   nxt = 1'b1;
                    CM_RESET: nxt = 1'b0;
                    default:  nxt = state;
                endcase
            end
            default: nxt = state;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_sync_channel.sv
// One S/R channel: synchronisers, glitch filters, state bit, change pulse,
// sticky conflict flag and tri-state Q/Qbar drivers.
module sr_sync_channel
    import sr_sync_pkg::*;
#(
    parameter int             SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int             FILTER        = DEF_FILTER,
    parameter conflict_mode_t CONFLICT_MODE = DEF_CONFLICT_MODE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    input  logic r,
    input  logic clr_conflict,
    output wire  q,
    output wire  qbar,
    output logic changed,
    output logic conflict
);

    // The filter registers act as the final synchroniser rank: they sample
    // the output of the first SYNC_STAGES-1 flops, so that an accepted level
    // appears on the filtered value at edge SYNC_STAGES+FILTER-1.
    localparam int                 SN       = SYNC_STAGES - 1;
    localparam int                 CNT_W    = $clog2(FILTER + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FILTER - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    // Index 0 carries S, index 1 carries R.
    logic [1:0]       raw;
    logic [1:0]       sync_q [SN];
    logic [1:0]       filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q  [2];
    logic [CNT_W-1:0] cnt_d  [2];
    logic             both;
    logic             state_q, state_d;
    logic             changed_q, changed_d;
    logic             conflict_q, conflict_d;
    logic             float_q, float_d;

    assign raw  = {r, s};
    assign both = &filt_q;

    // Synchroniser shift chains for S and R.
    // NOTE: every flop in the chain is reset, so a reset mid-transfer cannot
    // leave a stale level that the filter would later accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SN; k++) sync_q[k] <= '0;
        end else begin
            // NOTE: non-blocking so each stage takes its neighbour's old value.
            sync_q[0] <= raw;
            for (int k = 1; k < SN; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // Glitch filter: count while the synchronised level differs from the
    // filtered one; accept it once the difference has lasted FILTER cycles.
    always_comb begin
        // NOTE: defaults first so no path leaves a target unassigned (latch).
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync_q[SN-1][i] != filt_q[i]) begin
                if (cnt_q[i] >= CNT_LAST) begin
                    filt_d[i] = sync_q[SN-1][i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Filter value and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q   <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            filt_q   <= filt_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    // State update, change detection, sticky conflict and float request.
    always_comb begin
        state_d    = next_state(filt_q[0], filt_q[1], state_q, CONFLICT_MODE);
        changed_d  = state_d ^ state_q;
        conflict_d = both | (conflict_q & ~clr_conflict);
        float_d    = (CONFLICT_MODE == CM_FLOAT) && both;
    end

    // Output-side registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= 1'b0;
            changed_q  <= 1'b0;
            conflict_q <= 1'b0;
            float_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            changed_q  <= changed_d;
            conflict_q <= conflict_d;
            float_q    <= float_d;
        end
    end

    assign q        = float_q ? 1'bz : state_q;
    assign qbar     = float_q ? 1'bz : ~state_q;
    assign changed  = changed_q;
    assign conflict = conflict_q;

endmodule

// File: rtl/sr_sync_bank.sv
// Bank of independent synchronised S/R state bits.
module sr_sync_bank
    import sr_sync_pkg::*;
#(
    parameter int             CHANNELS      = DEF_CHANNELS,
    parameter int             SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int             FILTER        = DEF_FILTER,
    parameter conflict_mode_t CONFLICT_MODE = DEF_CONFLICT_MODE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] s,
    input  logic [CHANNELS-1:0] r,
    input  logic [CHANNELS-1:0] clr_conflict,
    output wire  [CHANNELS-1:0] q,
    output wire  [CHANNELS-1:0] qbar,
    output logic [CHANNELS-1:0] changed,
    output logic [CHANNELS-1:0] conflict
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        sr_sync_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER       (FILTER),
            .CONFLICT_MODE(CONFLICT_MODE)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .s           (s[g]),
            .r           (r[g]),
            .clr_conflict(clr_conflict[g]),
            .q           (q[g]),
            .qbar        (qbar[g]),
            .changed     (changed[g]),
            .conflict    (conflict[g])
        );
    end

endmodule

// File: tb/tb_sr_sync_bank.sv
// Directed bench for sr_sync_bank: one instance per conflict mode sharing
// stimulus, plus a SYNC_STAGES=3 / FILTER=1 single-channel instance.
module tb_sr_sync_bank;
    import sr_sync_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] s, r, clr;

    wire  [3:0] q_h, qb_h, q_s, qb_s, q_r, qb_r, q_f, qb_f;
    logic [3:0] ch_h, cf_h, ch_s, cf_s, ch_r, cf_r, ch_f, cf_f;

    logic       sw_s, sw_r, sw_clr;
    wire        sw_q, sw_qb;
    logic       sw_ch, sw_cf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sr_sync_bank #(.CONFLICT_MODE(CM_HOLD)) dut_hold (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr_conflict(clr),
        .q(q_h), .qbar(qb_h), .changed(ch_h), .conflict(cf_h));

    sr_sync_bank #(.CONFLICT_MODE(CM_SET)) dut_set (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr_conflict(clr),
        .q(q_s), .qbar(qb_s), .changed(ch_s), .conflict(cf_s));

    sr_sync_bank #(.CONFLICT_MODE(CM_RESET)) dut_rst (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr_conflict(clr),
        .q(q_r), .qbar(qb_r), .changed(ch_r), .conflict(cf_r));

    sr_sync_bank #(.CONFLICT_MODE(CM_FLOAT)) dut_flt (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr_conflict(clr),
        .q(q_f), .qbar(qb_f), .changed(ch_f), .conflict(cf_f));

    sr_sync_bank #(.CHANNELS(1), .SYNC_STAGES(3), .FILTER(1)) dut_sw (
        .clk(clk), .rst_n(rst_n), .s(sw_s), .r(sw_r), .clr_conflict(sw_clr),
        .q(sw_q), .qbar(sw_qb), .changed(sw_ch), .conflict(sw_cf));

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; s = '0; r = '0; clr = '0;
        sw_s = 1'b0; sw_r = 1'b0; sw_clr = 1'b0;

        // Power-on reset values.
        #12;
        check("rst_q",        q_h,  4'b0000);
        check("rst_qbar",     qb_h, 4'b1111);
        check("rst_changed",  ch_h, 4'b0000);
        check("rst_conflict", cf_h, 4'b0000);
        check("rst_qbar_flt", qb_f, 4'b1111);

        // Release, start setting all channels, then reset mid-count.
        @(posedge clk); #1;
        rst_n = 1'b1;
        s = 4'b1111;
        tick(3);
        rst_n = 1'b0;
        #1;
        check("midrst_q",        q_h,  4'b0000);
        check("midrst_qbar",     qb_h, 4'b1111);
        check("midrst_conflict", cf_h, 4'b0000);
        tick(1);
        rst_n = 1'b1;
        tick(4);
        check("set_all_edge4_q", q_h, 4'b0000);
        tick(1);
        check("set_all_edge5_q",  q_h,  4'b1111);
        check("set_all_edge5_qb", qb_h, 4'b0000);
        check("set_all_edge5_ch", ch_h, 4'b1111);
        tick(1);
        check("set_all_edge6_ch", ch_h, 4'b0000);

        // Dropping S holds the state.
        s = 4'b0000;
        tick(6);
        check("hold_after_s_drop", q_h,  4'b1111);
        check("hold_no_change",    ch_h, 4'b0000);

        // Reset then set channel 0.
        r = 4'b0001;
        tick(4);
        check("r0_edge4_q", q_h, 4'b1111);
        tick(1);
        check("r0_edge5_q",  q_h,  4'b1110);
        check("r0_edge5_ch", ch_h, 4'b0001);
        tick(1);
        check("r0_edge6_ch", ch_h, 4'b0000);
        r = 4'b0000;
        tick(6);
        s = 4'b0001;
        tick(4);
        check("s0_edge4_q", q_h, 4'b1110);
        tick(1);
        check("s0_edge5_q",  q_h,  4'b1111);
        check("s0_edge5_ch", ch_h, 4'b0001);
        tick(1);
        check("s0_edge6_ch", ch_h, 4'b0000);
        s = 4'b0000;
        tick(6);

        // Two-cycle R pulse on channel 1 is rejected.
        r = 4'b0010;
        tick(2);
        r = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check("glitch2_q",  q_h,  4'b1111);
            check("glitch2_ch", ch_h, 4'b0000);
        end

        // Three-cycle R pulse on channel 1 is accepted.
        r = 4'b0010;
        tick(3);
        r = 4'b0000;
        tick(1);
        check("glitch3_edge4_q", q_h, 4'b1111);
        tick(1);
        check("glitch3_edge5_q",  q_h,  4'b1101);
        check("glitch3_edge5_ch", ch_h, 4'b0010);
        tick(6);

        // Bring channel 2 to 0 before the conflict test.
        r = 4'b0100;
        tick(5);
        check("r2_q", q_h, 4'b1001);
        r = 4'b0000;
        tick(6);

        // Channel 2 conflict for 10 cycles in every mode.
        s = 4'b0100;
        r = 4'b0100;
        tick(6);
        check("cm_hold_q",      q_h, 4'b1001);
        check("cm_set_q",       q_s, 4'b1101);
        check("cm_reset_q",     q_r, 4'b1001);
        check("cm_float_rel",   {3'b000, ({q_f[2], qb_f[2]} !== 2'b01)}, 4'b0001);
        check("cm_float_other", {q_f[3], q_f[1:0]}, {1'b1, 2'b01});
        check("cm_hold_cf",     cf_h, 4'b0100);
        check("cm_set_cf",      cf_s, 4'b0100);
        check("cm_reset_cf",    cf_r, 4'b0100);
        check("cm_float_cf",    cf_f, 4'b0100);
        tick(4);
        s = 4'b0000;
        r = 4'b0000;
        tick(4);
        check("cm_float_still_rel", {3'b000, ({q_f[2], qb_f[2]} !== 2'b01)}, 4'b0001);
        tick(1);
        check("cm_float_q_back",  q_f,  4'b1001);
        check("cm_float_qb_back", qb_f, 4'b0110);
        check("cm_float_no_ch",   ch_f, 4'b0000);
        check("cm_set_q_kept",    q_s,  4'b1101);
        check("cm_hold_cf_stick", cf_h, 4'b0100);
        clr = 4'b0100;
        tick(1);
        clr = 4'b0000;
        check("clr_hold_cf",  cf_h, 4'b0000);
        check("clr_set_cf",   cf_s, 4'b0000);
        check("clr_reset_cf", cf_r, 4'b0000);
        check("clr_float_cf", cf_f, 4'b0000);

        // Clear collides with a new conflict on channel 3; channel 0 resets.
        s = 4'b1000;
        r = 4'b1001;
        tick(3);
        clr = 4'b1000;
        tick(2);
        clr = 4'b0000;
        check("collide_cf", cf_h, 4'b1000);
        check("collide_q",  q_h,  4'b1000);
        check("collide_ch", ch_h, 4'b0001);
        s = 4'b0000;
        r = 4'b0000;
        tick(6);
        clr = 4'b1000;
        tick(1);
        clr = 4'b0000;
        check("collide_clr_cf", cf_h, 4'b0000);

        // SYNC_STAGES=3, FILTER=1: four-edge latency and 1-cycle pulses pass.
        sw_s = 1'b1;
        tick(3);
        check("sweep_edge3_q", {3'b000, sw_q}, 4'b0000);
        tick(1);
        check("sweep_edge4_q",  {3'b000, sw_q},  4'b0001);
        check("sweep_edge4_ch", {3'b000, sw_ch}, 4'b0001);
        sw_s = 1'b0;
        tick(4);
        sw_r = 1'b1;
        tick(1);
        sw_r = 1'b0;
        tick(2);
        check("sweep_pulse_edge3_q", {3'b000, sw_q}, 4'b0001);
        tick(1);
        check("sweep_pulse_edge4_q",  {3'b000, sw_q},  4'b0000);
        check("sweep_pulse_edge4_qb", {3'b000, sw_qb}, 4'b0001);
        check("sweep_cf",             {3'b000, sw_cf}, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
